// File: rtl/seq_detect_pkg.sv
// Shared types and sizing helpers for the programmable serial sequence detector.
package seq_detect_pkg;

  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 32;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ARMED = 2'd1,
    MATCH = 2'd2
  } state_e;

  // Width of the history fill counter, which must hold 0..pat_w-1.
  function automatic int fill_width(input int pat_w);
    return (pat_w > 1) ? $clog2(pat_w) : 1;
  endfunction

endpackage

// File: rtl/seq_history.sv
// Serial history shift register with a saturating count of valid history bits.
module seq_history
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 4,
  localparam int FW = fill_width(PAT_W)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             accept_i,
  input  logic             clear_i,
  input  logic             bit_i,
  output logic [PAT_W-2:0] hist_o,
  output logic [FW-1:0]    fill_o,
  output logic             full_o
);

  localparam logic [FW-1:0] FILL_MAX = FW'(PAT_W - 1);

  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [PAT_W-1:0] shifted;

  assign shifted = {hist_q, bit_i};

  // Clear wins over accept so a non-overlapping hit restarts from an empty history.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (accept_i) begin
      hist_d = shifted[PAT_W-2:0];
      fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist_o = hist_q;
  assign fill_o = fill_q;
  assign full_o = (fill_q == FILL_MAX);

endmodule

// File: rtl/seq_detect_prog.sv
// Run-time programmable serial sequence detector with Mealy/Moore flags and a
// saturating match counter.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int             PAT_W   = 4,
  parameter int             CNT_W   = 8,
  parameter logic [PAT_W-1:0] PAT_RST = '0
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             flag_mealy,
  output logic             flag_moore,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FW = fill_width(PAT_W);

  logic [PAT_W-1:0] pattern_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q;
  logic             moore_q;

  logic [PAT_W-2:0] hist;
  logic [FW-1:0]    fill;
  logic             full;
  logic             accept;
  logic             hit;
  logic             hist_clear;
  logic             fill_reached;

  // A load cycle swallows any incoming bit.
  assign accept     = in_valid & ~pat_load;
  assign hit        = accept & full & ({hist, in} == pattern_q);
  assign hist_clear = pat_load | (hit & ~overlap);

  // True when the history will be full after the bit being accepted now.
  assign fill_reached = full | (fill == FW'(PAT_W - 2));

  seq_history #(
    .PAT_W(PAT_W)
  ) u_history (
    .clock   (clock),
    .rst     (rst),
    .accept_i(accept),
    .clear_i (hist_clear),
    .bit_i   (in),
    .hist_o  (hist),
    .fill_o  (fill),
    .full_o  (full)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      pattern_q <= PAT_RST;
    end else if (pat_load) begin
      pattern_q <= pat_in;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      moore_q <= 1'b0;
    end else if (pat_load) begin
      state_q <= FILL;
      moore_q <= 1'b0;
    end else if (accept) begin
      if (hit) begin
        state_q <= MATCH;
        moore_q <= 1'b1;
      end else begin
        state_q <= fill_reached ? ARMED : FILL;
        moore_q <= 1'b0;
      end
    end
  end

  // A clear coinciding with a hit still records that hit.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = hit ? CNT_W'(1) : '0;
    end else if (hit && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign flag_mealy = hit;
  assign flag_moore = moore_q;
  assign match_cnt  = cnt_q;
  assign cnt_sat    = &cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: an 8-bit-counter instance and a 2-bit-counter
// instance share all stimulus.
module tb_seq_detect_prog;

  logic       clock = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       pat_load;
  logic [3:0] pat_in;
  logic       overlap;
  logic       cnt_clr;

  logic       flag_mealy, flag_moore, cnt_sat;
  logic [7:0] match_cnt;
  logic       flag_mealy2, flag_moore2, cnt_sat2;
  logic [1:0] match_cnt2;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic       mealy;
    logic       moore;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic       sat2;
  } exp_t;

  exp_t expQ[$];

  always #5 clock = ~clock;

  seq_detect_prog #(.PAT_W(4), .CNT_W(8)) dut (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in_bit),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .overlap   (overlap),
    .cnt_clr   (cnt_clr),
    .flag_mealy(flag_mealy),
    .flag_moore(flag_moore),
    .match_cnt (match_cnt),
    .cnt_sat   (cnt_sat)
  );

  seq_detect_prog #(.PAT_W(4), .CNT_W(2)) dut2 (
    .clock     (clock),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in_bit),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .overlap   (overlap),
    .cnt_clr   (cnt_clr),
    .flag_mealy(flag_mealy2),
    .flag_moore(flag_moore2),
    .match_cnt (match_cnt2),
    .cnt_sat   (cnt_sat2)
  );

  // Pulse reset for a cycle, then load a pattern with no bit accepted.
  task automatic restart(input logic [3:0] p, input logic ov);
    @(negedge clock);
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    @(negedge clock);
    rst = 1'b1; pat_load = 1'b1; pat_in = p; overlap = ov;
  endtask

  task automatic send(input logic v, input logic b, input logic ld, input logic [3:0] pin,
                      input logic clr, input exp_t e);
    @(negedge clock);
    in_valid = v; in_bit = b; pat_load = ld; pat_in = pin; cnt_clr = clr;
    expQ.push_back(e);
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    checks++;
    if (flag_mealy !== 1'b0) begin fails++; $display("[TB] FAIL reset_mealy: got %b expected 0", flag_mealy); end
    checks++;
    if (flag_moore !== 1'b0) begin fails++; $display("[TB] FAIL reset_moore: got %b expected 0", flag_moore); end
    checks++;
    if (match_cnt !== 8'd0) begin fails++; $display("[TB] FAIL reset_cnt: got %0d expected 0", match_cnt); end
    checks++;
    if (cnt_sat !== 1'b0) begin fails++; $display("[TB] FAIL reset_sat: got %b expected 0", cnt_sat); end
    checks++;
    if (match_cnt2 !== 2'd0) begin fails++; $display("[TB] FAIL reset_cnt2: got %0d expected 0", match_cnt2); end
  endtask

  task automatic test_overlap();
    logic [6:0] bits = 7'b1101101;
    logic [6:0] hits = 7'b0001001;
    int cnt [7] = '{0, 0, 0, 1, 1, 1, 2};
    exp_t e;
    restart(4'b1101, 1'b1);
    for (int i = 0; i < 7; i++) begin
      send(1'b1, bits[6-i], 1'b0, 4'h0, 1'b0,
           exp_t'{mealy: hits[6-i], moore: hits[6-i], cnt: 8'(cnt[i]), cnt2: 2'(cnt[i]), sat2: 1'b0});
      #2;
      e = expQ.pop_front();
      checks++;
      if (flag_mealy !== e.mealy) begin fails++; $display("[TB] FAIL overlap_mealy bit %0d: got %b expected %b", i + 1, flag_mealy, e.mealy); end
      @(posedge clock); #1;
      checks++;
      if (flag_moore !== e.moore) begin fails++; $display("[TB] FAIL overlap_moore bit %0d: got %b expected %b", i + 1, flag_moore, e.moore); end
      checks++;
      if (match_cnt !== e.cnt) begin fails++; $display("[TB] FAIL overlap_cnt bit %0d: got %0d expected %0d", i + 1, match_cnt, e.cnt); end
    end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] bits = 7'b1101101;
    logic [6:0] hits = 7'b0001000;
    int cnt [7] = '{0, 0, 0, 1, 1, 1, 1};
    exp_t e;
    restart(4'b1101, 1'b0);
    for (int i = 0; i < 7; i++) begin
      send(1'b1, bits[6-i], 1'b0, 4'h0, 1'b0,
           exp_t'{mealy: hits[6-i], moore: hits[6-i], cnt: 8'(cnt[i]), cnt2: 2'(cnt[i]), sat2: 1'b0});
      #2;
      e = expQ.pop_front();
      checks++;
      if (flag_mealy !== e.mealy) begin fails++; $display("[TB] FAIL nonoverlap_mealy bit %0d: got %b expected %b", i + 1, flag_mealy, e.mealy); end
      @(posedge clock); #1;
      checks++;
      if (flag_moore !== e.moore) begin fails++; $display("[TB] FAIL nonoverlap_moore bit %0d: got %b expected %b", i + 1, flag_moore, e.moore); end
      checks++;
      if (match_cnt !== e.cnt) begin fails++; $display("[TB] FAIL nonoverlap_cnt bit %0d: got %0d expected %0d", i + 1, match_cnt, e.cnt); end
    end
  endtask

  task automatic test_gaps();
    logic [7:0] vld   = 8'b11100100;
    logic [7:0] bits  = 8'b11011101;
    logic [7:0] mealy = 8'b00000100;
    logic [7:0] moore = 8'b00000111;
    int cnt [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    exp_t e;
    restart(4'b1101, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(vld[7-i], bits[7-i], 1'b0, 4'h0, 1'b0,
           exp_t'{mealy: mealy[7-i], moore: moore[7-i], cnt: 8'(cnt[i]), cnt2: 2'(cnt[i]), sat2: 1'b0});
      #2;
      e = expQ.pop_front();
      checks++;
      if (flag_mealy !== e.mealy) begin fails++; $display("[TB] FAIL gaps_mealy step %0d: got %b expected %b", i, flag_mealy, e.mealy); end
      @(posedge clock); #1;
      checks++;
      if (flag_moore !== e.moore) begin fails++; $display("[TB] FAIL gaps_moore step %0d: got %b expected %b", i, flag_moore, e.moore); end
      checks++;
      if (match_cnt !== e.cnt) begin fails++; $display("[TB] FAIL gaps_cnt step %0d: got %0d expected %0d", i, match_cnt, e.cnt); end
    end
  endtask

  task automatic test_pat_load();
    logic [7:0] bits = 8'b11010110;
    logic [7:0] load = 8'b00010000;
    logic [7:0] hits = 8'b00000001;
    int cnt [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    exp_t e;
    restart(4'b1101, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, bits[7-i], load[7-i], 4'b0110, 1'b0,
           exp_t'{mealy: hits[7-i], moore: hits[7-i], cnt: 8'(cnt[i]), cnt2: 2'(cnt[i]), sat2: 1'b0});
      #2;
      e = expQ.pop_front();
      checks++;
      if (flag_mealy !== e.mealy) begin fails++; $display("[TB] FAIL patload_mealy step %0d: got %b expected %b", i, flag_mealy, e.mealy); end
      @(posedge clock); #1;
      checks++;
      if (flag_moore !== e.moore) begin fails++; $display("[TB] FAIL patload_moore step %0d: got %b expected %b", i, flag_moore, e.moore); end
      checks++;
      if (match_cnt !== e.cnt) begin fails++; $display("[TB] FAIL patload_cnt step %0d: got %0d expected %0d", i, match_cnt, e.cnt); end
    end
  endtask

  task automatic test_saturation();
    logic [9:0] vld   = 10'b1111111110;
    logic [9:0] clr   = 10'b0000000011;
    logic [9:0] mealy = 10'b0001111110;
    logic [9:0] moore = 10'b0001111111;
    int cnt  [10] = '{0, 0, 0, 1, 2, 3, 4, 5, 1, 0};
    int cnt2 [10] = '{0, 0, 0, 1, 2, 3, 3, 3, 1, 0};
    logic [9:0] sat2 = 10'b0000011100;
    exp_t e;
    restart(4'b1111, 1'b1);
    for (int i = 0; i < 10; i++) begin
      send(vld[9-i], 1'b1, 1'b0, 4'h0, clr[9-i],
           exp_t'{mealy: mealy[9-i], moore: moore[9-i], cnt: 8'(cnt[i]), cnt2: 2'(cnt2[i]), sat2: sat2[9-i]});
      #2;
      e = expQ.pop_front();
      checks++;
      if (flag_mealy2 !== e.mealy) begin fails++; $display("[TB] FAIL sat_mealy step %0d: got %b expected %b", i, flag_mealy2, e.mealy); end
      @(posedge clock); #1;
      checks++;
      if (flag_moore2 !== e.moore) begin fails++; $display("[TB] FAIL sat_moore step %0d: got %b expected %b", i, flag_moore2, e.moore); end
      checks++;
      if (match_cnt2 !== e.cnt2) begin fails++; $display("[TB] FAIL sat_cnt2 step %0d: got %0d expected %0d", i, match_cnt2, e.cnt2); end
      checks++;
      if (cnt_sat2 !== e.sat2) begin fails++; $display("[TB] FAIL sat_flag2 step %0d: got %b expected %b", i, cnt_sat2, e.sat2); end
      checks++;
      if (match_cnt !== e.cnt) begin fails++; $display("[TB] FAIL sat_cnt8 step %0d: got %0d expected %0d", i, match_cnt, e.cnt); end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] bits = 4'b1101;
    logic [3:0] hits = 4'b0001;
    int cnt [4] = '{0, 0, 0, 1};
    exp_t e;
    restart(4'b1101, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, bits[3-i], 1'b0, 4'h0, 1'b0,
           exp_t'{mealy: hits[3-i], moore: hits[3-i], cnt: 8'(cnt[i]), cnt2: 2'(cnt[i]), sat2: 1'b0});
      @(posedge clock); #1;
      e = expQ.pop_front();
      checks++;
      if (flag_moore !== e.moore) begin fails++; $display("[TB] FAIL arst_pre_moore bit %0d: got %b expected %b", i + 1, flag_moore, e.moore); end
      checks++;
      if (match_cnt !== e.cnt) begin fails++; $display("[TB] FAIL arst_pre_cnt bit %0d: got %0d expected %0d", i + 1, match_cnt, e.cnt); end
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (flag_moore !== 1'b0) begin fails++; $display("[TB] FAIL arst_moore: got %b expected 0", flag_moore); end
    checks++;
    if (match_cnt !== 8'd0) begin fails++; $display("[TB] FAIL arst_cnt: got %0d expected 0", match_cnt); end
    checks++;
    if (flag_mealy !== 1'b0) begin fails++; $display("[TB] FAIL arst_mealy: got %b expected 0", flag_mealy); end
    @(negedge clock);
    in_valid = 1'b1; in_bit = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (flag_moore !== 1'b0 || match_cnt !== 8'd0) begin
      fails++;
      $display("[TB] FAIL arst_hold: got moore %b cnt %0d expected 0 0", flag_moore, match_cnt);
    end
    @(negedge clock);
    rst = 1'b1; in_valid = 1'b0;
    // Pattern is back to all zeros: three zeros must not match, the fourth must.
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b0, 1'b0, 4'h0, 1'b0,
           exp_t'{mealy: hits[3-i], moore: hits[3-i], cnt: 8'(cnt[i]), cnt2: 2'(cnt[i]), sat2: 1'b0});
      #2;
      e = expQ.pop_front();
      checks++;
      if (flag_mealy !== e.mealy) begin fails++; $display("[TB] FAIL arst_post_mealy bit %0d: got %b expected %b", i + 1, flag_mealy, e.mealy); end
      @(posedge clock); #1;
      checks++;
      if (match_cnt !== e.cnt) begin fails++; $display("[TB] FAIL arst_post_cnt bit %0d: got %0d expected %0d", i + 1, match_cnt, e.cnt); end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b1; in_bit = 1'b1; pat_load = 1'b0;
    pat_in = 4'h0; overlap = 1'b1; cnt_clr = 1'b0;
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_gaps();
    test_pat_load();
    test_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
